// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared types and helpers for the ALU operand/opcode sequencer.
//   - state_t   : sequencer FSM states
//   - alu_op_t  : user opcodes 0..9 as entered on the switches
//   - SEL_NOP   : {btn_change, mode} value the ALU treats as a no-op
//   - op_to_sel : opcode -> 4-bit {btn_change, mode} select
//   - phase_of  : state -> one-hot LED phase indicator
package alu_seq_pkg;

  typedef enum logic [2:0] {
    GET_Z  = 3'd0,
    GET_Y  = 3'd1,
    GET_OP = 3'd2,
    RUN    = 3'd3,
    HOLD   = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } alu_op_t;

  localparam logic [3:0] SEL_NOP = 4'b0100;

  // Highest legal opcode; 10..15 on the switches are rejected.
  localparam logic [3:0] OP_LAST = 4'd9;

  // Upper two bits select the ALU group (btn_change), lower two the mode.
  function automatic logic [3:0] op_to_sel(input alu_op_t op);
    logic [3:0] sel;
    case (op)
      OP_ADD:  sel = 4'b1100;
      OP_SUB:  sel = 4'b1101;
      OP_MUL:  sel = 4'b1110;
      OP_DIV:  sel = 4'b1111;
      OP_MOD:  sel = 4'b1000;
      OP_AND:  sel = 4'b1001;
      OP_OR:   sel = 4'b1010;
      OP_XOR:  sel = 4'b1011;
      OP_SHL:  sel = 4'b0010;
      OP_SHR:  sel = 4'b0001;
      default: sel = SEL_NOP;
    endcase
    return sel;
  endfunction

  // RUN and HOLD both show all LEDs off.
  function automatic logic [2:0] phase_of(input state_t s);
    logic [2:0] ph;
    case (s)
      GET_Z:   ph = 3'b001;
      GET_Y:   ph = 3'b010;
      GET_OP:  ph = 3'b100;
      default: ph = 3'b000;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_btn_debounce.sv
// btn_debounce
//   Turns a raw, bouncy, active-low push-button into a single-cycle press
//   pulse. A 2-FF synchronizer feeds a stability counter; the accepted
//   (stable) level only follows the synchronized level once it has been
//   different for DEB_CYCLES consecutive cycles. A stable 1->0 transition
//   yields one registered press pulse; releases yield nothing.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   key_n  in  raw active-low key
//   press  out one-cycle pulse per accepted press
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          key_meta_q, key_meta_d;
  logic          key_sync_q, key_sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // The counter restarts whenever the synchronized level agrees with the
  // accepted level, so any bounce shorter than DEB_CYCLES is discarded.
  always_comb begin
    key_meta_d = key_n;
    key_sync_d = key_meta_q;
    stable_d   = stable_q;
    cnt_d      = cnt_q;
    press_d    = 1'b0;
    if (key_sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = key_sync_q;
      cnt_d    = '0;
      press_d  = ~key_sync_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      stable_q   <= 1'b1;
      cnt_q      <= '0;
      press_q    <= 1'b0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      press_q    <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Front end for the lab-3 combinational ALU. Z, Y and a 4-bit opcode are
//   entered in turn on the switches, each confirmed with the debounced
//   KEY0 press; KEY1 clears everything back to Z entry. The captured
//   operands, the encoded {btn_change, mode} select and op_valid are held
//   stable until the user starts a new calculation.
// Ports:
//   clk         in  system clock
//   rst_n       in  synchronous active-low reset
//   sw[N]       in  data switches (opcode in sw[3:0])
//   key_next_n  in  raw active-low confirm key
//   key_clr_n   in  raw active-low clear key
//   Z[N], Y[N]  out registered operands
//   mode[2]     out registered ALU mode select
//   btn_change[2] out registered ALU group select
//   op_valid    out high in RUN/HOLD
//   op_err      out one-cycle pulse on an illegal opcode confirm
//   phase[3]    out one-hot LED phase (001 Z, 010 Y, 100 OP, 000 run)
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic         key_next_n,
  input  logic         key_clr_n,
  output logic [N-1:0] Z,
  output logic [N-1:0] Y,
  output logic [1:0]   mode,
  output logic [1:0]   btn_change,
  output logic         op_valid,
  output logic         op_err,
  output logic [2:0]   phase
);

  logic next_pulse;
  logic clr_pulse;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_next_n),
    .press (next_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_clr_n),
    .press (clr_pulse)
  );

  state_t       state_q, state_d;
  logic [N-1:0] z_q, z_d;
  logic [N-1:0] y_q, y_d;
  logic [3:0]   sel_q, sel_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic [2:0]   phase_q, phase_d;

  logic [3:0]   op_code;
  logic         op_legal;

  assign op_code  = sw[3:0];
  assign op_legal = (op_code <= OP_LAST);

  // Clear has priority over confirm. The select only ever leaves SEL_NOP
  // on a legal GET_OP accept and is forced back on leaving HOLD, so it
  // reads as a no-op everywhere outside RUN/HOLD.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    y_d     = y_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    if (clr_pulse) begin
      state_d = GET_Z;
      z_d     = '0;
      y_d     = '0;
      sel_d   = SEL_NOP;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        GET_Z: begin
          if (next_pulse) begin
            z_d     = sw;
            state_d = GET_Y;
          end
        end
        GET_Y: begin
          if (next_pulse) begin
            y_d     = sw;
            state_d = GET_OP;
          end
        end
        GET_OP: begin
          if (next_pulse) begin
            if (op_legal) begin
              sel_d   = op_to_sel(alu_op_t'(op_code));
              valid_d = 1'b1;
              state_d = RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        RUN: begin
          state_d = HOLD;
        end
        HOLD: begin
          if (next_pulse) begin
            sel_d   = SEL_NOP;
            valid_d = 1'b0;
            state_d = GET_Z;
          end
        end
        default: begin
          state_d = GET_Z;
          sel_d   = SEL_NOP;
          valid_d = 1'b0;
        end
      endcase
    end
    phase_d = phase_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= GET_Z;
      z_q     <= '0;
      y_q     <= '0;
      sel_q   <= SEL_NOP;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= 3'b001;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      phase_q <= phase_d;
    end
  end

  assign Z          = z_q;
  assign Y          = y_q;
  assign mode       = sel_q[1:0];
  assign btn_change = sel_q[3:2];
  assign op_valid   = valid_q;
  assign op_err     = err_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Directed plus randomized stimulus for alu_op_sequencer with a small
//   behavioural reference model of the operand/opcode entry sequence.
module tb_alu_op_sequencer;

  localparam int N   = 4;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sw;
  logic         key_next_n;
  logic         key_clr_n;
  logic [N-1:0] Z;
  logic [N-1:0] Y;
  logic [1:0]   mode;
  logic [1:0]   btn_change;
  logic         op_valid;
  logic         op_err;
  logic [2:0]   phase;

  int checks   = 0;
  int failures = 0;

  // Reference model: entry step 0=Z, 1=Y, 2=opcode, 3=running.
  int         step;
  logic [3:0] expZ, expY, expSel;
  logic       expValid, expErr;
  logic [2:0] expPhase;
  logic [3:0] selTable [0:9];

  alu_op_sequencer #(.N(N), .DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .key_next_n (key_next_n),
    .key_clr_n  (key_clr_n),
    .Z          (Z),
    .Y          (Y),
    .mode       (mode),
    .btn_change (btn_change),
    .op_valid   (op_valid),
    .op_err     (op_err),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_Z"},     {4'b0, Z},                 {4'b0, expZ});
    checkVal({tag, "_Y"},     {4'b0, Y},                 {4'b0, expY});
    checkVal({tag, "_sel"},   {4'b0, btn_change, mode},  {4'b0, expSel});
    checkVal({tag, "_valid"}, {7'b0, op_valid},          {7'b0, expValid});
    checkVal({tag, "_err"},   {7'b0, op_err},            {7'b0, expErr});
    checkVal({tag, "_phase"}, {5'b0, phase},             {5'b0, expPhase});
  endtask

  task automatic modelClr();
    step     = 0;
    expZ     = '0;
    expY     = '0;
    expSel   = 4'b0100;
    expValid = 1'b0;
    expErr   = 1'b0;
    expPhase = 3'b001;
  endtask

  task automatic modelNext(input logic [3:0] v);
    expErr = 1'b0;
    if (step == 0) begin
      expZ = v; step = 1; expPhase = 3'b010;
    end else if (step == 1) begin
      expY = v; step = 2; expPhase = 3'b100;
    end else if (step == 2) begin
      if (v < 4'd10) begin
        expSel = selTable[v]; expValid = 1'b1; expPhase = 3'b000; step = 3;
      end else begin
        expErr = 1'b1;
      end
    end else begin
      expSel = 4'b0100; expValid = 1'b0; expPhase = 3'b001; step = 0;
    end
  endtask

  // Starts at a negedge. The key press takes effect at the (DEB+3)th edge;
  // sw carries junk except in the pulse cycle to prove it is sampled then.
  task automatic applyStimulus(input string tag, input bit doNext, input bit doClr,
                               input logic [3:0] v);
    sw         = 4'($urandom);
    key_next_n = !doNext;
    key_clr_n  = !doClr;
    repeat (DEB + 2) @(negedge clk);
    checkOutput({tag, "_pre"});
    sw = v;
    @(negedge clk);
    if (doClr) modelClr();
    else if (doNext) modelNext(v);
    checkOutput({tag, "_post"});
    sw     = 4'($urandom);
    expErr = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_after"});
    key_next_n = 1'b1;
    key_clr_n  = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    checkOutput({tag, "_settle"});
  endtask

  initial begin
    selTable = '{4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1000,
                 4'b1001, 4'b1010, 4'b1011, 4'b0010, 4'b0001};
    rst_n      = 1'b0;
    sw         = '0;
    key_next_n = 1'b1;
    key_clr_n  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelClr();
    repeat (20) @(negedge clk);
    checkOutput("idle");

    // Basic entry 5, 3, ADD, then hold.
    applyStimulus("enterZ", 1'b1, 1'b0, 4'd5);
    applyStimulus("enterY", 1'b1, 1'b0, 4'd3);
    applyStimulus("enterOp", 1'b1, 1'b0, 4'd0);
    repeat (50) @(negedge clk);
    checkOutput("hold50");

    // Leave HOLD, then clear.
    applyStimulus("leaveHold", 1'b1, 1'b0, 4'd7);
    applyStimulus("clr", 1'b0, 1'b1, 4'd0);

    // Bouncy press: short lows must be ignored, the held low counts once.
    sw = 4'd5;
    for (int i = 0; i < 4; i++) begin
      key_next_n = 1'b0;
      repeat (2) @(negedge clk);
      key_next_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    checkOutput("bounceNone");
    key_next_n = 1'b0;
    repeat (DEB + 3) @(negedge clk);
    modelNext(4'd5);
    checkOutput("bounceAdv");
    sw = 4'($urandom);
    repeat (12) @(negedge clk);
    checkOutput("heldSingle");
    key_next_n = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    checkOutput("bounceRel");

    // Illegal then legal opcode.
    applyStimulus("enterY2", 1'b1, 1'b0, 4'd3);
    applyStimulus("illegal12", 1'b1, 1'b0, 4'd12);
    applyStimulus("illegal15", 1'b1, 1'b0, 4'd15);
    applyStimulus("legal9", 1'b1, 1'b0, 4'd9);

    // Simultaneous next and clr in GET_Y.
    applyStimulus("leaveHold2", 1'b1, 1'b0, 4'd0);
    applyStimulus("enterZ3", 1'b1, 1'b0, 4'd1);
    applyStimulus("both", 1'b1, 1'b1, 4'd8);

    // Reset in the middle of GET_OP.
    applyStimulus("enterZ4", 1'b1, 1'b0, 4'd6);
    applyStimulus("enterY4", 1'b1, 1'b0, 4'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelClr();
    checkOutput("midReset");

    // Randomized sequence of confirms and clears.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      applyStimulus("rndClr", 1'b0, 1'b1, 4'($urandom));
      else if (r == 1) applyStimulus("rndBoth", 1'b1, 1'b1, 4'($urandom));
      else             applyStimulus("rndNext", 1'b1, 1'b0, 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
